leaky_relu_backward: RTL and testbench

- Backward-pass counterpart of the forward leaky ReLU activation.
- During the forward pass it caches one derivative bit per pre-activation (z > 0).
- During the backward pass it consumes incoming gradients in the same order and scales each by the cached derivative: 1 if z > 0, else leak_factor.
- Sits between the backward gradient stream and the weight-gradient / previous-layer accumulation path of the systolic array.

---
 rtl/leaky_relu_backward.sv | 130 +++++++++++++
 tb/tb_leaky_relu_backward.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaky_relu_backward.sv
// Leaky ReLU backward stage: caches one derivative bit per forward pre-activation
// (z > 0) and scales incoming gradients by 1 or leak_factor in the same order.
module leaky_relu_backward #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           fwd_valid_in,
  input  logic signed [WIDTH-1:0]        fwd_z_in,
  input  logic                           grad_valid_in,
  input  logic signed [WIDTH-1:0]        grad_in,
  input  logic signed [WIDTH-1:0]        leak_factor,
  output logic                           grad_valid_out,
  output logic signed [WIDTH-1:0]        grad_out,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic signed [PW-1:0] SatMax = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [PW-1:0] SatMin = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  logic [DEPTH-1:0]        cache_q;
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic                    full_q, empty_q;
  logic                    overflow_q, underflow_q;
  logic                    grad_valid_q;
  logic signed [WIDTH-1:0] grad_q, grad_d;

  logic                    fwd_bit;
  logic                    rd_ok, wr_ok, ovf_set, unf_set;
  logic signed [PW-1:0]    grad_ext, leak_ext, prod, shifted;
  logic signed [WIDTH-1:0] leaky_res;

  // Cache control: a read frees a slot so a write into a full cache can land the same cycle.
  always_comb begin
    fwd_bit = !fwd_z_in[WIDTH-1] && (fwd_z_in != '0);
    rd_ok   = grad_valid_in && !empty_q;
    wr_ok   = fwd_valid_in && (!full_q || rd_ok);
    ovf_set = fwd_valid_in && full_q && !rd_ok;
    // No bypass: a gradient into an empty cache underflows even if a write lands now.
    unf_set = grad_valid_in && empty_q;
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CW'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  // Gradient scaling: full-width product, floor shift by FRAC, then saturate.
  always_comb begin
    grad_ext = {{WIDTH{grad_in[WIDTH-1]}}, grad_in};
    leak_ext = {{WIDTH{leak_factor[WIDTH-1]}}, leak_factor};
    prod     = grad_ext * leak_ext;
    shifted  = prod >>> FRAC;
    if (shifted > SatMax) begin
      leaky_res = SatMax[WIDTH-1:0];
    end else if (shifted < SatMin) begin
      leaky_res = SatMin[WIDTH-1:0];
    end else begin
      leaky_res = shifted[WIDTH-1:0];
    end
    if (!rd_ok) begin
      grad_d = '0;
    end else if (cache_q[rd_ptr_q]) begin
      grad_d = grad_in;
    end else begin
      grad_d = leaky_res;
    end
  end

  // Derivative-bit storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_ok) begin
      cache_q[wr_ptr_q] <= fwd_bit;
    end
  end

  // Pointers, occupancy, sticky flags and the registered gradient output.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      grad_valid_q <= 1'b0;
      grad_q       <= '0;
    end else if (flush) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      grad_valid_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q      <= count_d;
      full_q       <= (count_d == CW'(DEPTH));
      empty_q      <= (count_d == '0);
      overflow_q   <= overflow_q | ovf_set;
      underflow_q  <= underflow_q | unf_set;
      grad_valid_q <= grad_valid_in;
      if (grad_valid_in) grad_q <= grad_d;
    end
  end

  assign grad_valid_out = grad_valid_q;
  assign grad_out       = grad_q;
  assign count          = count_q;
  assign full           = full_q;
  assign empty          = empty_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;

endmodule

// File: tb/tb_leaky_relu_backward.sv
// Directed bench for leaky_relu_backward (WIDTH=16, FRAC=8, DEPTH=16).
module tb_leaky_relu_backward;

  logic        clk, rst, flush;
  logic        fwd_valid_in, grad_valid_in;
  logic [15:0] fwd_z_in, grad_in, leak_factor;
  logic        grad_valid_out;
  logic [15:0] grad_out;
  logic [4:0]  count;
  logic        full, empty, overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  leaky_relu_backward #(.WIDTH(16), .FRAC(8), .DEPTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .fwd_valid_in   (fwd_valid_in),
    .fwd_z_in       (fwd_z_in),
    .grad_valid_in  (grad_valid_in),
    .grad_in        (grad_in),
    .leak_factor    (leak_factor),
    .grad_valid_out (grad_valid_out),
    .grad_out       (grad_out),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        fv;
    logic [15:0] z;
    logic        gv;
    logic [15:0] g;
    logic [15:0] leak;
    logic        e_gvo;
    logic [15:0] e_go;
    logic [4:0]  e_cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic [15:0] z, input logic gv,
                       input logic [15:0] g, input logic [15:0] lk);
    fwd_valid_in  = fv;
    fwd_z_in      = z;
    grad_valid_in = gv;
    grad_in       = g;
    leak_factor   = lk;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    flush = 1'b0;
    idle();
    step();
    rst = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [4:0] cnt,
                              input logic ovf, input logic unf);
    check({tag, " count"}, 32'(count), 32'(cnt));
    check({tag, " full"}, 32'(full), 32'(cnt == 5'd16));
    check({tag, " empty"}, 32'(empty), 32'(cnt == 5'd0));
    check({tag, " overflow"}, 32'(overflow), 32'(ovf));
    check({tag, " underflow"}, 32'(underflow), 32'(unf));
  endtask

  // Q8.8 reference: pass-through for positive z, else floor((g*leak)/256) saturated.
  function automatic logic [15:0] model(input logic b, input logic [15:0] g,
                                        input logic [15:0] lk);
    longint p;
    if (b) return g;
    p = longint'($signed(g)) * longint'($signed(lk));
    p = p >>> 8;
    if (p > 32767) p = 32767;
    else if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  logic        exp_bits[16];
  logic [15:0] bz, bg, bl;

  initial begin
    vecs[0]  = '{1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'd1};
    vecs[1]  = '{1'b1, 16'hFF00, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'd2};
    vecs[2]  = '{1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'd3};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 16'h0200, 16'h0080, 1'b1, 16'h0200, 5'd2};
    vecs[4]  = '{1'b0, 16'h0000, 1'b1, 16'h0200, 16'h0080, 1'b1, 16'h0100, 5'd1};
    vecs[5]  = '{1'b0, 16'h0000, 1'b1, 16'hFD00, 16'h0080, 1'b1, 16'hFE80, 5'd0};
    vecs[6]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hFE80, 5'd0};
    vecs[7]  = '{1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hFE80, 5'd1};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 16'h6400, 16'h0200, 1'b1, 16'h7FFF, 5'd0};
    vecs[9]  = '{1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h7FFF, 5'd1};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 16'h9C00, 16'h0200, 1'b1, 16'h8000, 5'd0};
    vecs[11] = '{1'b1, 16'h8000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h8000, 5'd1};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 16'h0100, 16'hFF80, 1'b1, 16'hFF80, 5'd0};
    vecs[13] = '{1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hFF80, 5'd1};
    vecs[14] = '{1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'h0080, 1'b1, 16'hFFFF, 5'd0};
    vecs[15] = '{1'b1, 16'h7FFF, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 5'd1};
    vecs[16] = '{1'b1, 16'h0001, 1'b1, 16'h1234, 16'h0080, 1'b1, 16'h1234, 5'd1};
    vecs[17] = '{1'b0, 16'h0000, 1'b1, 16'h0300, 16'h0000, 1'b1, 16'h0300, 5'd0};

    do_reset();
    check("reset gvo", 32'(grad_valid_out), 32'd0);
    check("reset go", 32'(grad_out), 32'd0);
    check_status("reset", 5'd0, 1'b0, 1'b0);

    // Table: basic pass, saturation, negative leak, floor rounding, concurrent access.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].fv, vecs[i].z, vecs[i].gv, vecs[i].g, vecs[i].leak);
      step();
      check($sformatf("vec%0d gvo", i), 32'(grad_valid_out), 32'(vecs[i].e_gvo));
      check($sformatf("vec%0d go", i), 32'(grad_out), 32'(vecs[i].e_go));
      check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].e_cnt == 5'd0));
    end
    idle();
    check_status("table end", 5'd0, 1'b0, 1'b0);

    // Full and wrap: offset pointers by 3, then DEPTH+1 writes and 16 reads.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0100, 1'b0, 16'h0, 16'h0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h0, 1'b1, 16'h0200, 16'h0080);
      step();
    end
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, (i % 2 == 0) ? 16'h0100 : 16'hFF00, 1'b0, 16'h0, 16'h0);
      if (i < 16) exp_bits[i] = (i % 2 == 0);
      step();
    end
    idle();
    check_status("after 17 writes", 5'd16, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 16'h0, 1'b1, 16'h0200, 16'h0080);
      step();
      check($sformatf("wrap rd%0d gvo", i), 32'(grad_valid_out), 32'd1);
      check($sformatf("wrap rd%0d go", i), 32'(grad_out),
            32'(exp_bits[i] ? 16'h0200 : 16'h0100));
    end
    idle();
    check_status("after drain", 5'd0, 1'b1, 1'b0);

    // Simultaneous write and read while full.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, (i == 0) ? 16'hFF00 : 16'h0100, 1'b0, 16'h0, 16'h0);
      step();
    end
    drive(1'b1, 16'h0100, 1'b1, 16'h0200, 16'h0080);
    step();
    idle();
    check("full rw gvo", 32'(grad_valid_out), 32'd1);
    check("full rw go", 32'(grad_out), 32'h0100);
    check_status("full rw", 5'd16, 1'b0, 1'b0);

    // Simultaneous write and read while empty: no bypass, write still lands.
    do_reset();
    drive(1'b1, 16'h0100, 1'b1, 16'h0200, 16'h0080);
    step();
    check("empty rw gvo", 32'(grad_valid_out), 32'd1);
    check("empty rw go", 32'(grad_out), 32'h0000);
    check_status("empty rw", 5'd1, 1'b0, 1'b1);
    drive(1'b0, 16'h0, 1'b1, 16'h0300, 16'h0080);
    step();
    check("empty rw follow go", 32'(grad_out), 32'h0300);

    // Flush with concurrent traffic: cleared cache, flags kept, output held.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h0100, 1'b0, 16'h0, 16'h0);
      step();
    end
    idle();
    check_status("pre flush", 5'd5, 1'b0, 1'b1);
    flush = 1'b1;
    drive(1'b1, 16'h0100, 1'b1, 16'h0200, 16'h0080);
    step();
    flush = 1'b0;
    idle();
    check("flush gvo", 32'(grad_valid_out), 32'd0);
    check("flush go hold", 32'(grad_out), 32'h0300);
    check_status("flush", 5'd0, 1'b0, 1'b1);
    drive(1'b0, 16'h0, 1'b1, 16'h0200, 16'h0080);
    step();
    check("post flush go", 32'(grad_out), 32'h0000);
    check("post flush gvo", 32'(grad_valid_out), 32'd1);

    // Reset mid-stream with traffic on the inputs.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'h0100, 1'b0, 16'h0, 16'h0);
      step();
    end
    rst = 1'b1;
    drive(1'b1, 16'h0100, 1'b1, 16'h0200, 16'h0080);
    step();
    rst = 1'b0;
    idle();
    check("midrst gvo", 32'(grad_valid_out), 32'd0);
    check("midrst go", 32'(grad_out), 32'd0);
    check_status("midrst", 5'd0, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 1'b1, 16'h0200, 16'h0080);
    step();
    idle();
    check("post rst go", 32'(grad_out), 32'h0000);
    check_status("post rst", 5'd0, 1'b0, 1'b1);

    // Back-to-back: 16 writes, then 16 gradients with no bubbles.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0:       bz = 16'h0100 + 16'(i);
        1:       bz = 16'hFF00 - 16'(i);
        2:       bz = 16'h0000;
        default: bz = 16'h8000 + 16'(i);
      endcase
      exp_bits[i] = ($signed(bz) > 0);
      drive(1'b1, bz, 1'b0, 16'h0, 16'h0);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      bg = 16'(i * 2417) ^ 16'h5A3C;
      bl = 16'(i * 48 + 16);
      drive(1'b0, 16'h0, 1'b1, bg, bl);
      step();
      check($sformatf("b2b%0d gvo", i), 32'(grad_valid_out), 32'd1);
      check($sformatf("b2b%0d go", i), 32'(grad_out), 32'(model(exp_bits[i], bg, bl)));
    end
    idle();
    step();
    check("b2b tail gvo", 32'(grad_valid_out), 32'd0);
    check_status("b2b end", 5'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
